// File: rtl/flip_heuristic_selector.sv
// Break-count accumulator and flip selector feeding the temporal buffer.
// Define FLIP_NOISE_EN to enable the LFSR-driven WalkSAT random pick.
module flip_heuristic_selector #(
  parameter int unsigned NSAT = 3,
  parameter int unsigned CW   = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [$clog2(NSAT)-1:0] cand_index_i,
  input  logic                    brk_valid_i,
  input  logic                    brk_i,
  input  logic                    cand_done_i,
  input  logic [7:0]              noise_i,
  input  logic                    sel_ready_i,
  output logic                    sel_valid_o,
  output logic [$clog2(NSAT)-1:0] sel_index_o,
  output logic [CW-1:0]           sel_count_o,
  output logic                    sel_random_o,
  output logic                    busy_o
);

  localparam int unsigned IW = $clog2(NSAT);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SELECT,
    HOLD
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q [NSAT];
  logic [CW-1:0]   cnt_d [NSAT];
  logic [NSAT-1:0] done_q;
  logic [NSAT-1:0] done_d;
  logic            sel_valid_q;
  logic [IW-1:0]   sel_index_q;
  logic [CW-1:0]   sel_count_q;
  logic            sel_random_q;

  logic            idx_ok;
  logic [IW-1:0]   g_idx;
  logic [CW-1:0]   g_cnt;
  logic [IW-1:0]   p_idx;
  logic [CW-1:0]   p_cnt;
  logic            p_rnd;

  assign idx_ok = 32'(cand_index_i) < NSAT;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (state_q == ACCUM && brk_valid_i && idx_ok) begin
      if (brk_i && cnt_q[cand_index_i] != CMAX)
        cnt_d[cand_index_i] = cnt_q[cand_index_i] + 1'b1;
      if (cand_done_i)
        done_d[cand_index_i] = 1'b1;
    end
  end

  // strict compare keeps the lowest index on ties
  always_comb begin
    g_idx = '0;
    g_cnt = cnt_q[0];
    for (int i = 1; i < NSAT; i++) begin
      if (cnt_q[i] < g_cnt) begin
        g_idx = IW'(i);
        g_cnt = cnt_q[i];
      end
    end
  end

`ifdef FLIP_NOISE_EN
  logic [15:0]   lfsr_q;
  logic          rnd_hit;
  logic [IW-1:0] r_idx;

  assign rnd_hit = lfsr_q[7:0] < noise_i;
  assign r_idx   = IW'(lfsr_q[15:8] % 8'(NSAT));
  assign p_idx   = rnd_hit ? r_idx : g_idx;
  assign p_cnt   = rnd_hit ? cnt_q[r_idx] : g_cnt;
  assign p_rnd   = rnd_hit;

  // Galois form of x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]}
              ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  logic unused_noise;

  assign unused_noise = ^noise_i;
  assign p_idx        = g_idx;
  assign p_cnt        = g_cnt;
  assign p_rnd        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      done_q       <= '0;
      sel_valid_q  <= 1'b0;
      sel_index_q  <= '0;
      sel_count_q  <= '0;
      sel_random_q <= 1'b0;
      for (int i = 0; i < NSAT; i++)
        cnt_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACCUM;
            done_q  <= '0;
            for (int i = 0; i < NSAT; i++)
              cnt_q[i] <= '0;
          end
        end
        ACCUM: begin
          if (start_i) begin
            done_q <= '0;
            for (int i = 0; i < NSAT; i++)
              cnt_q[i] <= '0;
          end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (&done_d)
              state_q <= SELECT;
          end
        end
        SELECT: begin
          sel_valid_q  <= 1'b1;
          sel_index_q  <= p_idx;
          sel_count_q  <= p_cnt;
          sel_random_q <= p_rnd;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (sel_ready_i) begin
            sel_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_valid_o  = sel_valid_q;
  assign sel_index_o  = sel_index_q;
  assign sel_count_o  = sel_count_q;
  assign sel_random_o = sel_random_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/flip_heuristic_selector.md
# flip_heuristic_selector

Upstream neighbour of the temporal buffer. While the clause-evaluation datapath streams the clauses touched by each of the NSAT flip candidates, this block accumulates a per-candidate break count. Once all candidates are done, it selects the flip to commit: minimum break count, or a WalkSAT-style random pick when noise is enabled. The chosen index drives the temporal buffer's read index and is held until the controller accepts it.

## Interface
- NSAT, 3: flip candidates per step (≥2).
- CW, 8: break-counter width.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  pulse; begin a new selection step.
- cand_index_i  in  $clog2(NSAT)  candidate being evaluated; same value as the temporal buffer's write index.
- brk_valid_i  in  1  one clause result present.
- brk_i  in  1  clause breaks if this candidate is flipped.
- cand_done_i  in  1  last clause for cand_index_i.
- noise_i  in  8  random-walk threshold; probability ≈ noise_i/256.
- sel_ready_i  in  1  controller accepts the selection.
- sel_valid_o  out  1  selection valid.
- sel_index_o  out  $clog2(NSAT)  chosen candidate.
- sel_count_o  out  CW  break count of the chosen candidate.
- sel_random_o  out  1  selection came from the random path.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, SELECT, HOLD.
- IDLE:
  - start_i → ACCUM.
  - Entering ACCUM clears all counters and the done mask.
- ACCUM:
  - brk_valid_i && brk_i increments cnt[cand_index_i].
  - Counters saturate at 2^CW−1.
  - brk_valid_i && cand_done_i sets done[cand_index_i]. A break in the same cycle is counted.
  - A repeated cand_done_i for an already-done candidate has no effect.
  - Done mask all ones → SELECT.
  - cand_index_i ≥ NSAT is ignored.
  - start_i in ACCUM restarts the step: counters and mask cleared.
- SELECT (one cycle):
  - Greedy pick is the minimum cnt. Ties go to the lowest index.
  - Outputs registered; sel_random_o as per Configuration. Next state HOLD.
- HOLD:
  - sel_valid_o = 1; sel_index_o, sel_count_o and sel_random_o stay stable.
  - sel_valid_o && sel_ready_i → IDLE.
  - start_i and brk_valid_i are ignored.
- brk_valid_i, cand_done_i and sel_ready_i are ignored in states where they are not listed above.

## Timing
- Reset (rst_i low, async):
  - state IDLE; counters, done mask, sel_valid_o, sel_index_o, sel_count_o, sel_random_o and busy_o all 0.
  - LFSR = SEED.
- start_i sampled at edge N:
  - ACCUM from N; busy_o = 1 after N.
  - Clause inputs count from edge N+1.
- Final cand_done_i sampled at edge M:
  - SELECT after M.
  - Outputs registered and sel_valid_o = 1 after edge M+1.
- Handshake at edge H:
  - sel_valid_o = 0 and busy_o = 0 after H.
  - start_i is accepted no earlier than H+1.
- Minimum step length: NSAT+3 cycles.
- Reset mid-operation aborts immediately; no partial selection is emitted.

## Configuration
- FLIP_NOISE_EN defined:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances every cycle.
  - In SELECT, if lfsr[7:0] < noise_i: sel_index_o = lfsr[15:8] mod NSAT, sel_count_o = that candidate's count, sel_random_o = 1.
  - Otherwise greedy pick, sel_random_o = 0.
  - noise_i = 0 is always greedy.
- FLIP_NOISE_EN undefined:
  - No LFSR, greedy only; sel_random_o tied to 0; noise_i unused.

## Test plan
- Greedy, NSAT=3: breaks 4/1/3 for candidates 0/1/2 → sel_index_o=1, sel_count_o=1, sel_valid_o high 2 cycles after final cand_done_i.
- Tie: counts 2/2/5 → sel_index_o=0, sel_count_o=2. All-zero counts → index 0, count 0.
- Saturation, CW=4: 20 breaks on candidate 0; candidates 1 and 2 get 16 and 15 breaks → all saturate at 15; tie-break gives sel_index_o=0, sel_count_o=15.
- Backpressure: sel_ready_i low 5 cycles → outputs stable and busy_o=1. Pulse sel_ready_i → next cycle sel_valid_o=0, busy_o=0. Next start_i → counters start from 0.
- Reset mid-ACCUM: rst_i low between clauses → all outputs 0 asynchronously. A following clean run 0/3/3 yields index 0.
- FLIP_NOISE_EN:
  - noise_i=0 over 100 steps → sel_random_o never set.
  - noise_i=255 over 256 steps → sel_random_o set on ≥240, sel_index_o always < NSAT.
  - LFSR sequence after reset matches the model from SEED.
